seg_scanner: RTL and testbench

SEG_SCANNER -- requirements
Module: seg_scanner

---
 rtl/seg_scanner_pkg.sv | 23 ++
 rtl/seg_scanner_if.sv | 23 ++
 rtl/seg_scan_timer.sv | 33 +++
 rtl/seg_scanner.sv | 110 +++++++++++
 tb/tb_seg_scanner.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scanner_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package seg_scanner_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef enum logic [2:0] {
    IDLE,
    BLANK,
    LOAD,
    STROBE,
    SHOW
  } scan_state_e;

  function automatic logic [NUM_DIGITS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/seg_scanner_if.sv
// Scanner-facing signal bundle: digit data in, decoder load and digit drive out.
interface seg_scanner_if;
  import seg_scanner_pkg::*;

  logic                          enable;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits;
  logic [NUM_DIGITS-1:0]         dots;
  logic [DIGIT_W-1:0]            bcd;
  logic                          dot;
  logic                          set;
  logic [NUM_DIGITS-1:0]         digit_en;

  modport master (
    input  enable, digits, dots,
    output bcd, dot, set, digit_en
  );

  modport slave (
    output enable, digits, dots,
    input  bcd, dot, set, digit_en
  );

endinterface

// File: rtl/seg_scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module seg_scan_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/seg_scanner.sv
// Four-digit multiplexed display scanner: blank, load decoder, strobe, then light one digit.
module seg_scanner
  import seg_scanner_pkg::*;
#(
  parameter int BLANK_CYCLES = 8,
  parameter int SHOW_CYCLES  = 2990
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scanner_if.master bus
);

  localparam int MAX_CYC = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  // Timer is loaded with N-1 on entry so the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(SHOW_CYCLES - 1);

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DIGIT_W-1:0]    bcd_q, bcd_d;
  logic                  dot_q, dot_d;
  logic                  set_q, set_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_val;
  logic                  tmr_done;

  seg_scan_timer #(.WIDTH(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Outputs are decoded for the state being entered, so they line up with state_q.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bcd_d      = bcd_q;
    dot_d      = dot_q;
    set_d      = 1'b0;
    digit_en_d = '0;
    tmr_load   = 1'b0;
    tmr_val    = BLANK_LD;
    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          tmr_load = 1'b1;
        end
        BLANK: begin
          if (tmr_done) begin
            state_d = LOAD;
            bcd_d   = bus.digits[idx_q*DIGIT_W +: DIGIT_W];
            dot_d   = bus.dots[idx_q];
          end
        end
        LOAD: begin
          state_d = STROBE;
          set_d   = 1'b1;
        end
        STROBE: begin
          state_d    = SHOW;
          tmr_load   = 1'b1;
          tmr_val    = SHOW_LD;
          digit_en_d = idx_onehot(idx_q);
        end
        SHOW: begin
          if (tmr_done) begin
            state_d  = BLANK;
            tmr_load = 1'b1;
            idx_d    = idx_q + 1'b1;
          end else begin
            digit_en_d = idx_onehot(idx_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      bcd_q      <= '0;
      dot_q      <= 1'b0;
      set_q      <= 1'b0;
      digit_en_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bcd_q      <= bcd_d;
      dot_q      <= dot_d;
      set_q      <= set_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign bus.bcd      = bcd_q;
  assign bus.dot      = dot_q;
  assign bus.set      = set_q;
  assign bus.digit_en = digit_en_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Bench for seg_scanner: per-cycle comparison against a period/position model plus invariant checks.
module tb_seg_scanner;

  localparam int B  = 2;
  localparam int S  = 4;
  localparam int P  = B + S + 2;
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] dig;
  logic [3:0]  dts;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: cycles since scanning started, and what the outputs should be.
  bit         m_active;
  int         m_k;
  logic [3:0] m_bcd;
  logic       m_dot;
  logic       m_set;
  logic [3:0] m_den;

  seg_scanner_if bus();
  assign bus.enable = en;
  assign bus.digits = dig;
  assign bus.dots   = dts;

  seg_scanner #(.BLANK_CYCLES(B), .SHOW_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int m_pos();
    return m_k % P;
  endfunction

  function automatic int m_dig();
    return (m_k / P) % ND;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_bcd    = 4'h0;
    m_dot    = 1'b0;
    m_set    = 1'b0;
    m_den    = 4'h0;
  endtask

  // Advance one clock: model consumes the inputs seen at the rising edge; returns at the falling edge.
  task automatic tick();
    int p;
    int d;
    @(posedge clk);
    if (!rst_n || !en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_k      = 0;
    end else begin
      m_k++;
    end
    m_set = 1'b0;
    m_den = 4'h0;
    if (m_active) begin
      p = m_pos();
      d = m_dig();
      if (p == B) begin
        m_bcd = dig[d*4 +: 4];
        m_dot = dts[d];
      end
      m_set = (p == B + 1);
      if (p >= B + 2) m_den = 4'(1 << d);
    end
    @(negedge clk);
  endtask

  task automatic restart();
    #2 rst_n = 1'b0;
    en = 1'b0;
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [3:0] prev_bcd = 4'h0;
  logic       prev_set = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total_cnt++;
      if ((bus.set === 1'b1 && bus.digit_en !== 4'h0) || !$onehot0(bus.digit_en) ||
          (bus.set === 1'b1 && prev_set !== 1'b1 && bus.bcd !== prev_bcd)) begin
        $display("FAIL invariant t=%0t set=%b digit_en=%b bcd=%h prev_bcd=%h", $time,
                 bus.set, bus.digit_en, bus.bcd, prev_bcd);
      end else begin
        pass_cnt++;
      end
    end
    prev_bcd = bus.bcd;
    prev_set = bus.set;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    dig   = 16'h0;
    dts   = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus.bcd !== 4'h0) $display("FAIL reset_bcd got=%h want=0", bus.bcd); else pass_cnt++;
    total_cnt++;
    if (bus.dot !== 1'b0) $display("FAIL reset_dot got=%b want=0", bus.dot); else pass_cnt++;
    total_cnt++;
    if (bus.set !== 1'b0) $display("FAIL reset_set got=%b want=0", bus.set); else pass_cnt++;
    total_cnt++;
    if (bus.digit_en !== 4'h0) $display("FAIL reset_digit_en got=%b want=0000", bus.digit_en);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    repeat (3) begin
      tick();
      total_cnt++;
      if (bus.digit_en !== 4'h0 || bus.set !== 1'b0)
        $display("FAIL idle_outputs got en=%b set=%b want en=0000 set=0", bus.digit_en, bus.set);
      else pass_cnt++;
    end
  endtask

  task automatic test_pattern();
    dig = 16'h4321;
    dts = 4'b0100;
    en  = 1'b1;
    for (int i = 0; i < 4 * P + 4; i++) begin
      tick();
      total_cnt++;
      if ({bus.bcd, bus.dot, bus.set, bus.digit_en} !== {m_bcd, m_dot, m_set, m_den})
        $display("FAIL pattern k=%0d got=%h want=%h", m_k,
                 {bus.bcd, bus.dot, bus.set, bus.digit_en}, {m_bcd, m_dot, m_set, m_den});
      else pass_cnt++;
      if (m_k == 2 * P + B) begin
        total_cnt++;
        if (bus.bcd !== 4'h3 || bus.dot !== 1'b1)
          $display("FAIL pattern_digit2 got bcd=%h dot=%b want bcd=3 dot=1", bus.bcd, bus.dot);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] seq[$];
    logic [3:0] last_den;
    logic [3:0] want;
    int         set_cnt;
    restart();
    dig      = 16'h4321;
    dts      = 4'b0100;
    en       = 1'b1;
    set_cnt  = 0;
    last_den = 4'h0;
    for (int i = 0; i < 3 * 4 * P; i++) begin
      tick();
      total_cnt++;
      if ({bus.bcd, bus.dot, bus.set, bus.digit_en} !== {m_bcd, m_dot, m_set, m_den})
        $display("FAIL wrap k=%0d got=%h want=%h", m_k,
                 {bus.bcd, bus.dot, bus.set, bus.digit_en}, {m_bcd, m_dot, m_set, m_den});
      else pass_cnt++;
      if (bus.set === 1'b1) set_cnt++;
      if (bus.digit_en !== 4'h0 && last_den === 4'h0) seq.push_back(bus.digit_en);
      last_den = bus.digit_en;
    end
    total_cnt++;
    if (set_cnt != 12) $display("FAIL wrap_set_pulses got=%0d want=12", set_cnt); else pass_cnt++;
    total_cnt++;
    if (seq.size() != 12) $display("FAIL wrap_seq_len got=%0d want=12", seq.size()); else pass_cnt++;
    for (int i = 0; i < seq.size(); i++) begin
      want = 4'(1 << (i % 4));
      total_cnt++;
      if (seq[i] !== want) $display("FAIL wrap_seq[%0d] got=%b want=%b", i, seq[i], want);
      else pass_cnt++;
    end
  endtask

  task automatic test_digit_change();
    bit found;
    restart();
    dig   = 16'h4321;
    dts   = 4'b0000;
    en    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (m_active && m_dig() == 1 && m_pos() == B + 3) found = 1'b1;
    end
    total_cnt++;
    if (!found) $display("FAIL change_reach_show1 got=timeout want=show_digit1"); else pass_cnt++;
    dig = 16'h9999;
    tick();
    total_cnt++;
    if (bus.bcd !== 4'h2) $display("FAIL change_hold got=%h want=2", bus.bcd); else pass_cnt++;
    for (int i = 0; i < 5 * P; i++) begin
      tick();
      total_cnt++;
      if ({bus.bcd, bus.dot, bus.set, bus.digit_en} !== {m_bcd, m_dot, m_set, m_den})
        $display("FAIL change k=%0d got=%h want=%h", m_k,
                 {bus.bcd, bus.dot, bus.set, bus.digit_en}, {m_bcd, m_dot, m_set, m_den});
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.bcd !== 4'h9) $display("FAIL change_new got=%h want=9", bus.bcd); else pass_cnt++;
  endtask

  task automatic test_enable_drop();
    bit found;
    restart();
    dig   = 16'h4321;
    dts   = 4'b0100;
    en    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (m_active && m_dig() == 2 && m_pos() == B + 3) found = 1'b1;
    end
    total_cnt++;
    if (!found) $display("FAIL drop_reach_show2 got=timeout want=show_digit2"); else pass_cnt++;
    en = 1'b0;
    tick();
    total_cnt++;
    if (bus.digit_en !== 4'h0) $display("FAIL drop_blank got=%b want=0000", bus.digit_en);
    else pass_cnt++;
    en    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 * P && !found; i++) begin
      tick();
      total_cnt++;
      if ({bus.bcd, bus.dot, bus.set, bus.digit_en} !== {m_bcd, m_dot, m_set, m_den})
        $display("FAIL drop k=%0d got=%h want=%h", m_k,
                 {bus.bcd, bus.dot, bus.set, bus.digit_en}, {m_bcd, m_dot, m_set, m_den});
      else pass_cnt++;
      if (bus.digit_en !== 4'h0) begin
        found = 1'b1;
        total_cnt++;
        if (bus.digit_en !== 4'b0001 || bus.bcd !== 4'h1)
          $display("FAIL drop_restart got en=%b bcd=%h want en=0001 bcd=1", bus.digit_en, bus.bcd);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (!found) $display("FAIL drop_relight got=timeout want=digit0_lit"); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bit found;
    restart();
    dig   = 16'h4321;
    dts   = 4'b1111;
    en    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 * P && !found; i++) begin
      tick();
      if (m_active && m_pos() == B + 1) found = 1'b1;
    end
    total_cnt++;
    if (!found || bus.set !== 1'b1) $display("FAIL areset_strobe got set=%b want=1", bus.set);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if (bus.set !== 1'b0) $display("FAIL areset_set got=%b want=0", bus.set); else pass_cnt++;
    total_cnt++;
    if (bus.digit_en !== 4'h0) $display("FAIL areset_digit_en got=%b want=0000", bus.digit_en);
    else pass_cnt++;
    total_cnt++;
    if (bus.bcd !== 4'h0 || bus.dot !== 1'b0)
      $display("FAIL areset_data got bcd=%h dot=%b want bcd=0 dot=0", bus.bcd, bus.dot);
    else pass_cnt++;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2 * P; i++) begin
      tick();
      total_cnt++;
      if ({bus.bcd, bus.dot, bus.set, bus.digit_en} !== {m_bcd, m_dot, m_set, m_den})
        $display("FAIL areset_resume k=%0d got=%h want=%h", m_k,
                 {bus.bcd, bus.dot, bus.set, bus.digit_en}, {m_bcd, m_dot, m_set, m_den});
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    restart();
    dig = 16'($urandom);
    dts = 4'($urandom);
    en  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      total_cnt++;
      if ({bus.bcd, bus.dot, bus.set, bus.digit_en} !== {m_bcd, m_dot, m_set, m_den})
        $display("FAIL random i=%0d got=%h want=%h", i,
                 {bus.bcd, bus.dot, bus.set, bus.digit_en}, {m_bcd, m_dot, m_set, m_den});
      else pass_cnt++;
      if ($urandom_range(0, 7) == 0) dig = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dts = 4'($urandom);
      en = ($urandom_range(0, 39) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_wrap();
    test_digit_change();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
